register_file: RTL

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/riscat_pkg.sv | 10 +
 rtl/reg_scoreboard.sv | 45 ++++
 rtl/register_file.sv | 71 +++++++
 3 files changed

// File: rtl/riscat_pkg.sv
// Shared constants and types for the riscat core: register addressing used by
// the register file and its busy-bit scoreboard.
package riscat_pkg;

    localparam int REG_ADDR_BITS = 5;
    localparam int NUM_REGS      = 32;

    typedef logic [REG_ADDR_BITS-1:0] reg_addr_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy tracking: a reservation marks a register as having a
// pending producer, and its write-back clears the mark again.
module reg_scoreboard
    import riscat_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      rsv_en,
    input  reg_addr_t rsv_addr,
    input  logic      wr_en,
    input  reg_addr_t wr_addr,
    input  reg_addr_t rs1_addr,
    input  reg_addr_t rs2_addr,
    output logic      rs1_busy,
    output logic      rs2_busy
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (rsv_en && rsv_addr != '0) set_vec[rsv_addr] = 1'b1;
        if (wr_en && wr_addr != '0)   clr_vec[wr_addr]  = 1'b1;
    end

    // Clear first, then set, so a same-cycle reservation beats the write-back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy <= '0;
        else       busy <= (busy & ~clr_vec) | set_vec;
    end

    // A register being written back this cycle is no longer waiting on it.
    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        if (!reset) begin
            rs1_busy = (rs1_addr != '0) && busy[rs1_addr] && !clr_vec[rs1_addr];
            rs2_busy = (rs2_addr != '0) && busy[rs2_addr] && !clr_vec[rs2_addr];
        end
    end

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file with write-back bypass and busy bits for
// registers that have an issued but not yet written-back producer.
module register_file #(
    parameter int DATA_BITS = 32,
    parameter int NUM_REGS  = riscat_pkg::NUM_REGS
)(
    input  logic                  clk,
    input  logic                  reset,
    input  riscat_pkg::reg_addr_t rs1_addr,
    input  riscat_pkg::reg_addr_t rs2_addr,
    output logic [DATA_BITS-1:0]  rs1_data,
    output logic [DATA_BITS-1:0]  rs2_data,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    input  logic                  rsv_en,
    input  riscat_pkg::reg_addr_t rsv_addr,
    input  logic                  wr_en,
    input  riscat_pkg::reg_addr_t wr_addr,
    input  logic [DATA_BITS-1:0]  wr_data
);

    logic [DATA_BITS-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]  wr_dec;

    always_comb begin
        wr_dec = '0;
        if (wr_en && wr_addr != '0) wr_dec[wr_addr] = 1'b1;
    end

    // Entry 0 is only ever loaded by reset, which keeps x0 hard-wired to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_dec[i]) regs[i] <= wr_data;
            end
        end
    end

    function automatic logic [DATA_BITS-1:0] read_port(input riscat_pkg::reg_addr_t addr);
        logic [DATA_BITS-1:0] value;
        value = '0;
        if (wr_dec[addr])       value = wr_data;
        else if (addr != '0)    value = regs[addr];
        return value;
    endfunction

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (!reset) begin
            rs1_data = read_port(rs1_addr);
            rs2_data = read_port(rs2_addr);
        end
    end

    reg_scoreboard u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy)
    );

endmodule
